mc_cmd_scheduler: RTL and testbench

- Sits between the trace-file parser and the DRAM command interface, inside the memory controller.
- Pulls parsed trace entries {time, op, addr} from the parser using the data_req/data_rdy handshake and buffers them in an in-order queue.
- Holds each entry until the simulated CPU cycle reaches its timestamp, then sequences PRE/ACT/RD/WR commands under an open-page policy with per-bank open-row tracking and DRAM timing counters.

---
 rtl/mc_pkg.sv | 69 ++++++
 rtl/mc_req_fifo.sv | 56 +++++
 rtl/mc_cmd_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_mc_cmd_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types for the memory-controller command scheduler.
//   cmd_e         : DRAM command encoding driven on cmd
//   memop_e       : trace op-codes understood by the scheduler
//   trace_entry_t : one parsed trace record {ts, op, addr}, ts in the MSBs
//   dram_addr_t   : decoded DRAM coordinates of a request
//   state_e       : scheduler FSM states
//   decode_line() : cache-line address -> DRAM coordinates
package mc_pkg;

  localparam int ADDR_W    = 36;
  localparam int MEMOP_W   = 12;
  localparam int TIME_W    = 12;
  localparam int ENTRY_W   = TIME_W + MEMOP_W + ADDR_W;
  localparam int LINE_W    = ADDR_W - 6;  // addr[5:0] is the byte offset within a line
  localparam int NUM_BANKS = 32;
  localparam int BIDX_W    = 5;           // {bg, bank}
  localparam int ROW_W     = 16;

  typedef enum logic [1:0] {
    CMD_PRE = 2'd0,
    CMD_ACT = 2'd1,
    CMD_RD  = 2'd2,
    CMD_WR  = 2'd3
  } cmd_e;

  typedef enum logic [MEMOP_W-1:0] {
    MEMOP_READ   = 12'd0,
    MEMOP_WRITE  = 12'd1,
    MEMOP_IFETCH = 12'd2
  } memop_e;

  typedef struct packed {
    logic [TIME_W-1:0]  ts;
    logic [MEMOP_W-1:0] op;
    logic [ADDR_W-1:0]  addr;
  } trace_entry_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [2:0]       bg;
    logic [1:0]       bank;
    logic [8:0]       col;
  } dram_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_RP,
    ST_ACT,
    ST_WAIT_RCD,
    ST_CAS,
    ST_WAIT_DATA
  } state_e;

  // line = addr[35:6]: col=addr[14:6], bg=addr[17:15], bank=addr[19:18], row=addr[35:20]
  function automatic dram_addr_t decode_line(input logic [LINE_W-1:0] line);
    dram_addr_t d;
    d.col  = line[8:0];
    d.bg   = line[11:9];
    d.bank = line[13:12];
    d.row  = line[29:14];
    return d;
  endfunction

  function automatic logic op_is_legal(input logic [MEMOP_W-1:0] op);
    return (op == MEMOP_READ) || (op == MEMOP_WRITE) || (op == MEMOP_IFETCH);
  endfunction

endpackage

// File: rtl/mc_req_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending trace entries.
//   clock, reset_n : clock and asynchronous active-low reset (flushes pointers)
//   push, wr_data  : write an entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   rd_data        : current head entry, valid while !empty
//   full, empty    : occupancy flags; count : number of stored entries
module mc_req_fifo #(
  parameter  int WIDTH = 60,
  parameter  int DEPTH = 16,            // power of 2
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; a slot is only
  // ever read after it has been written, so resetting it would buy nothing.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mc_cmd_scheduler.sv
// In-order DRAM command scheduler with open-page policy.
//   clock, reset_n : clock and asynchronous active-low reset
//   data_req       : registered; ready for a parser entry (!full && !shutdown)
//   data_rdy       : parser entry on data_read is valid this cycle
//   data_read      : {time, op, addr}
//   shutdown       : stop requesting entries; queued entries still drain
//   cycle          : free-running CPU cycle count
//   cmd_valid/cmd/cmd_bg/cmd_bank/cmd_row/cmd_col : one-cycle DRAM command
//   complete       : pulse when a request's data phase ends
//   err_op         : pulse the cycle after an illegal-op entry is dropped
//   overflow       : sticky; an entry arrived while the queue was full
//   done           : shutdown, queue empty and FSM idle
module mc_cmd_scheduler
  import mc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 36,
  parameter int MEMOP_WIDTH = 12,
  parameter int TIME_WIDTH  = 12,
  parameter int QDEPTH      = 16,
  parameter int T_RP        = 4,   // >= 2
  parameter int T_RCD       = 4,   // >= 2
  parameter int T_CL        = 6,
  parameter int T_BURST     = 2    // T_CL + T_BURST >= 2
) (
  input  logic                                        clock,
  input  logic                                        reset_n,
  output logic                                        data_req,
  input  logic                                        data_rdy,
  input  logic [TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH-1:0] data_read,
  input  logic                                        shutdown,
  output logic [63:0]                                 cycle,
  output logic                                        cmd_valid,
  output logic [1:0]                                  cmd,
  output logic [2:0]                                  cmd_bg,
  output logic [1:0]                                  cmd_bank,
  output logic [15:0]                                 cmd_row,
  output logic [8:0]                                  cmd_col,
  output logic                                        complete,
  output logic                                        err_op,
  output logic                                        overflow,
  output logic                                        done
);

  localparam int EW = TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;
  localparam int CW = $clog2(QDEPTH) + 1;

  // Wait states are entered one cycle after the command, and the next command
  // is registered on the last wait cycle, hence the "- 2".
  localparam logic [7:0] RP_INIT   = 8'(T_RP - 2);
  localparam logic [7:0] RCD_INIT  = 8'(T_RCD - 2);
  localparam logic [7:0] DATA_INIT = 8'(T_CL + T_BURST - 2);

  // ---------------- request queue ----------------
  logic [EW-1:0] fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic          in_legal;
  logic          push;
  logic          pop;

  state_e        state;
  logic [7:0]    wait_cnt;
  cmd_e          cmd_q;

  assign in_legal   = op_is_legal(data_read[ADDR_WIDTH +: MEMOP_WIDTH]);
  assign push       = data_rdy && in_legal && !fifo_full;
  assign pop        = (state == ST_CAS);
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  mc_req_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (data_read),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ---------------- head decode ----------------
  trace_entry_t      head;
  dram_addr_t        head_dec;
  logic [BIDX_W-1:0] head_idx;
  logic              head_eligible;
  logic              head_is_write;
  logic              head_hit;
  logic              unused_addr_lsbs;

  assign head             = trace_entry_t'(fifo_rd_data);
  assign head_dec         = decode_line(head.addr[ADDR_W-1:6]);
  assign head_idx         = {head_dec.bg, head_dec.bank};
  assign head_eligible    = !fifo_empty && (cycle >= 64'(head.ts));
  assign head_is_write    = (head.op == MEMOP_WRITE);
  assign unused_addr_lsbs = ^head.addr[5:0];

  // ---------------- bank tracking ----------------
  logic [NUM_BANKS-1:0] bank_open;
  logic [ROW_W-1:0]     bank_row [NUM_BANKS];
  logic                 act_issue;

  assign head_hit  = bank_open[head_idx] && (bank_row[head_idx] == head_dec.row);
  assign act_issue = ((state == ST_IDLE) && head_eligible && !bank_open[head_idx]) ||
                     ((state == ST_WAIT_RP) && (wait_cnt == '0));

  // Row tags are only meaningful while the matching bank_open bit is set.
  always_ff @(posedge clock) begin
    if (act_issue) bank_row[head_idx] <= head_dec.row;
  end

  // ---------------- scheduler FSM ----------------
  // The head is not popped until its CAS, so head_* stays stable from the
  // IDLE decision through PRE/ACT/CAS and the address fields are latched once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cmd_valid <= 1'b0;
      cmd_q     <= CMD_PRE;
      cmd_bg    <= '0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      complete  <= 1'b0;
      bank_open <= '0;
    end else begin
      cmd_valid <= 1'b0;
      complete  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (head_eligible) begin
            cmd_valid <= 1'b1;
            cmd_bg    <= head_dec.bg;
            cmd_bank  <= head_dec.bank;
            cmd_row   <= head_dec.row;
            cmd_col   <= head_dec.col;
            if (head_hit) begin
              state <= ST_CAS;
              cmd_q <= head_is_write ? CMD_WR : CMD_RD;
            end else if (bank_open[head_idx]) begin
              state               <= ST_PRE;
              cmd_q               <= CMD_PRE;
              bank_open[head_idx] <= 1'b0;
            end else begin
              state               <= ST_ACT;
              cmd_q               <= CMD_ACT;
              bank_open[head_idx] <= 1'b1;
            end
          end
        end
        ST_PRE: begin
          state    <= ST_WAIT_RP;
          wait_cnt <= RP_INIT;
        end
        ST_WAIT_RP: begin
          if (wait_cnt == '0) begin
            state               <= ST_ACT;
            cmd_valid           <= 1'b1;
            cmd_q               <= CMD_ACT;
            bank_open[head_idx] <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        ST_ACT: begin
          state    <= ST_WAIT_RCD;
          wait_cnt <= RCD_INIT;
        end
        ST_WAIT_RCD: begin
          if (wait_cnt == '0) begin
            state     <= ST_CAS;
            cmd_valid <= 1'b1;
            cmd_q     <= head_is_write ? CMD_WR : CMD_RD;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        ST_CAS: begin
          state    <= ST_WAIT_DATA;
          wait_cnt <= DATA_INIT;
        end
        ST_WAIT_DATA: begin
          if (wait_cnt == '0) begin
            state    <= ST_IDLE;
            complete <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd = cmd_q;

  // ---------------- status and cycle counter ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle    <= '0;
      data_req <= 1'b0;
      err_op   <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      cycle    <= cycle + 64'd1;
      // Look ahead at the post-edge occupancy so data_req drops right after
      // the accept that fills the queue.
      data_req <= (count_next != CW'(QDEPTH)) && !shutdown;
      err_op   <= data_rdy && !in_legal;
      overflow <= overflow || (data_rdy && fifo_full);
      done     <= shutdown && fifo_empty && (state == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_mc_cmd_scheduler.sv
`timescale 1ns/1ps
module tb_mc_cmd_scheduler;

  localparam logic [1:0] C_PRE = 2'd0;
  localparam logic [1:0] C_ACT = 2'd1;
  localparam logic [1:0] C_RD  = 2'd2;
  localparam logic [1:0] C_WR  = 2'd3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        data_req;
  logic        data_rdy = 1'b0;
  logic [59:0] data_read = '0;
  logic        shutdown = 1'b0;
  logic [63:0] cycle;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [8:0]  cmd_col;
  logic        complete;
  logic        err_op;
  logic        overflow;
  logic        done;

  always #5 clock = ~clock;

  mc_cmd_scheduler dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .data_req  (data_req),
    .data_rdy  (data_rdy),
    .data_read (data_read),
    .shutdown  (shutdown),
    .cycle     (cycle),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_bg    (cmd_bg),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .complete  (complete),
    .err_op    (err_op),
    .overflow  (overflow),
    .done      (done)
  );

  typedef struct {
    logic [1:0]  c;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [8:0]  col;
    int          cyc;
  } exp_cmd_t;

  exp_cmd_t cmd_q[$];
  int       cpl_q[$];
  int       total = 0;
  int       bad = 0;
  exp_cmd_t mon_e;
  int       mon_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_cmd_t mk(input logic [1:0] c, input logic [35:0] a, input int cyc);
    exp_cmd_t e;
    e.c    = c;
    e.col  = a[14:6];
    e.bg   = a[17:15];
    e.bank = a[19:18];
    e.row  = a[35:20];
    e.cyc  = cyc;
    return e;
  endfunction

  // Scoreboard: compare each issued command / completion against the queue.
  always @(negedge clock) begin
    if (reset_n) begin
      if (cmd_valid) begin
        check("cmd_expected", 64'(cmd_q.size() != 0), 64'd1);
        if (cmd_q.size() != 0) begin
          mon_e = cmd_q.pop_front();
          check("cmd_type", 64'(cmd), 64'(mon_e.c));
          check("cmd_cycle", cycle, 64'(mon_e.cyc));
          check("cmd_bg", 64'(cmd_bg), 64'(mon_e.bg));
          check("cmd_bank", 64'(cmd_bank), 64'(mon_e.bank));
          if (mon_e.c == C_ACT) check("cmd_row", 64'(cmd_row), 64'(mon_e.row));
          if (mon_e.c == C_RD || mon_e.c == C_WR) check("cmd_col", 64'(cmd_col), 64'(mon_e.col));
        end
      end
      if (complete) begin
        check("cpl_expected", 64'(cpl_q.size() != 0), 64'd1);
        if (cpl_q.size() != 0) begin
          mon_c = cpl_q.pop_front();
          check("cpl_cycle", cycle, 64'(mon_c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycle(input int n);
    for (int i = 0; i < 3000 && cycle != 64'(n); i++) tick();
    check("reach_cycle", cycle, 64'(n));
  endtask

  task automatic push(input logic [11:0] t, input logic [11:0] op, input logic [35:0] a);
    data_rdy  = 1'b1;
    data_read = {t, op, a};
    tick();
    data_rdy  = 1'b0;
  endtask

  localparam logic [35:0] A1 = 36'h000300000;  // bg0 bank0 row3 col0
  localparam logic [35:0] A2 = 36'h000300040;  // bg0 bank0 row3 col1
  localparam logic [35:0] A3 = 36'h000500000;  // bg0 bank0 row5 col0
  localparam logic [35:0] AB = 36'h000788000;  // bg1 bank2 row7
  localparam logic [35:0] AR = 36'h000950000;  // bg2 bank1 row9

  initial begin
    logic [35:0] a;
    logic [11:0] op;

    // ---- reset state ----
    #7;
    check("rst_cycle", cycle, 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_data_req", 64'(data_req), 64'd0);
    check("rst_complete", 64'(complete), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    #15 reset_n = 1'b1;
    tick();
    check("post_rst_cycle", cycle, 64'd1);
    check("post_rst_data_req", 64'(data_req), 64'd1);

    // ---- closed bank: ACT then RD ----
    cmd_q.push_back(mk(C_ACT, A1, 11));
    cmd_q.push_back(mk(C_RD, A1, 15));
    cpl_q.push_back(23);
    wait_cycle(2);
    push(12'd10, 12'd0, A1);

    // ---- row hit: WR without ACT ----
    cmd_q.push_back(mk(C_WR, A2, 24));
    cpl_q.push_back(32);
    wait_cycle(18);
    push(12'd0, 12'd1, A2);

    // ---- row conflict: PRE, ACT, RD ----
    cmd_q.push_back(mk(C_PRE, A3, 33));
    cmd_q.push_back(mk(C_ACT, A3, 37));
    cmd_q.push_back(mk(C_RD, A3, 41));
    cpl_q.push_back(49);
    wait_cycle(26);
    push(12'd0, 12'd0, A3);
    wait_cycle(50);
    check("basic_cmds_drained", 64'(cmd_q.size()), 64'd0);
    check("basic_cpls_drained", 64'(cpl_q.size()), 64'd0);

    // ---- illegal op ----
    wait_cycle(55);
    push(12'd0, 12'd7, A1);
    check("err_op_pulse", 64'(err_op), 64'd1);
    tick();
    check("err_op_clear", 64'(err_op), 64'd0);
    wait_cycle(75);
    check("err_op_no_overflow", 64'(overflow), 64'd0);
    check("err_op_data_req", 64'(data_req), 64'd1);

    // ---- fill queue and overflow ----
    for (int i = 0; i < 16; i++) begin
      a = AB + (36'(i) << 6);
      if (i == 0) cmd_q.push_back(mk(C_ACT, a, 1001));
      cmd_q.push_back(mk(((i % 3) == 1) ? C_WR : C_RD, a, 1005 + 9 * i));
      cpl_q.push_back(1013 + 9 * i);
    end
    wait_cycle(80);
    for (int i = 0; i < 17; i++) begin
      op = 12'(i % 3);
      push(12'd1000, op, AB + (36'(i) << 6));
      check($sformatf("fill_data_req_%0d", i), 64'(data_req), (i < 15) ? 64'd1 : 64'd0);
      check($sformatf("fill_overflow_%0d", i), 64'(overflow), (i == 16) ? 64'd1 : 64'd0);
    end
    wait_cycle(1000);
    check("overflow_sticky_1000", 64'(overflow), 64'd1);
    wait_cycle(1150);
    check("fill_cmds_drained", 64'(cmd_q.size()), 64'd0);
    check("fill_cpls_drained", 64'(cpl_q.size()), 64'd0);
    check("overflow_sticky_1150", 64'(overflow), 64'd1);

    // ---- reset during WAIT_RCD ----
    cmd_q.push_back(mk(C_ACT, AR, 1152));
    push(12'd0, 12'd0, AR);
    wait_cycle(1154);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cycle", cycle, 64'd0);
    check("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("mid_rst_cmd", 64'(cmd), 64'd0);
    check("mid_rst_fields", 64'({cmd_bg, cmd_bank, cmd_row, cmd_col}), 64'd0);
    check("mid_rst_data_req", 64'(data_req), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_misc", 64'({complete, err_op, done}), 64'd0);
    check("mid_rst_act_seen", 64'(cmd_q.size()), 64'd0);
    tick();
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    cmd_q.push_back(mk(C_ACT, AR, 5));
    cmd_q.push_back(mk(C_RD, AR, 9));
    cpl_q.push_back(17);
    wait_cycle(3);
    push(12'd0, 12'd0, AR);

    // ---- shutdown drains queued entries ----
    for (int i = 1; i <= 3; i++) begin
      a = AR + (36'(i) << 6);
      cmd_q.push_back(mk((i == 2) ? C_WR : C_RD, a, 22 + 9 * (i - 1)));
      cpl_q.push_back(30 + 9 * (i - 1));
    end
    wait_cycle(20);
    for (int i = 1; i <= 3; i++) push(12'd0, 12'(i - 1), AR + (36'(i) << 6));
    shutdown = 1'b1;
    tick();
    check("shutdown_data_req", 64'(data_req), 64'd0);
    check("shutdown_not_done", 64'(done), 64'd0);
    for (int i = 0; i < 200 && !done; i++) tick();
    check("shutdown_done", 64'(done), 64'd1);
    check("shutdown_cpls_before_done", 64'(cpl_q.size()), 64'd0);
    check("shutdown_cmds_drained", 64'(cmd_q.size()), 64'd0);
    check("shutdown_data_req_end", 64'(data_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
